// File: rtl/div_seq.sv
// div_seq: 32-bit restoring divider (LO=quotient, HI=remainder), one step per cycle.
// Define DIVU_SUPPORT_EN to honour is_unsigned; otherwise every division is signed.
module div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  input  logic        is_unsigned,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] lo,
  output logic [31:0] hi,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_FIX, S_DONE} state_t;
  state_t      r_state;
  logic [31:0] r_quot, r_dsr, r_rem, r_lo, r_hi;
  logic [4:0]  r_cnt;
  logic        r_qneg, r_rneg, r_busy, r_done, r_dz;
  logic        w_signed, w_dvd_neg, w_dsr_neg;
  logic [32:0] w_shift, w_trial;
`ifdef DIVU_SUPPORT_EN
  logic r_uns;
  assign w_signed = ~r_uns;
`else
  logic w_unused;
  assign w_unused = is_unsigned;
  assign w_signed = 1'b1;
`endif
  assign w_dvd_neg = w_signed & r_quot[31];
  assign w_dsr_neg = w_signed & r_dsr[31];
  // rem stays below the divisor magnitude, so 32 bits hold it; the trial needs 33
  assign w_shift   = {r_rem, r_quot[31]};
  assign w_trial   = w_shift - {1'b0, r_dsr};
  assign lo        = r_lo;
  assign hi        = r_hi;
  assign busy      = r_busy;
  assign done      = r_done;
  assign div_zero  = r_dz;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_quot  <= '0;
      r_dsr   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
`ifdef DIVU_SUPPORT_EN
      r_uns   <= 1'b0;
`endif
    end else if (clear) begin
      r_state <= S_IDLE;
      r_lo    <= '0;
      r_hi    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_dz   <= 1'b0;
          if (start) begin
            r_quot  <= dividend;
            r_dsr   <= divisor;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
`ifdef DIVU_SUPPORT_EN
            r_uns   <= is_unsigned;
`endif
          end
        end
        S_CHECK: begin
          if (r_dsr == '0) begin
            r_done  <= 1'b1;
            r_dz    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_quot  <= w_dvd_neg ? -r_quot : r_quot;
            r_dsr   <= w_dsr_neg ? -r_dsr : r_dsr;
            r_qneg  <= w_dvd_neg ^ w_dsr_neg;
            r_rneg  <= w_dvd_neg;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_rem   <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
          r_quot  <= {r_quot[30:0], ~w_trial[32]};
          r_cnt   <= r_cnt + 5'd1;
          r_state <= (r_cnt == 5'd31) ? S_FIX : S_RUN;
        end
        S_FIX: begin
          r_lo    <= r_qneg ? -r_quot : r_quot;
          r_hi    <= r_rneg ? -r_rem : r_rem;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_dz    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed checks of div_seq latency, signed results, divide-by-zero and aborts.
module tb_div_seq;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, clear = 1'b0, is_unsigned = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic [31:0] lo, hi;
  logic        busy, done, div_zero;
  int          total = 0, bad = 0, n;

  div_seq dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .is_unsigned(is_unsigned),
    .dividend(dividend), .divisor(divisor), .lo(lo), .hi(hi),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic u);
    @(negedge clk);
    dividend = a; divisor = b; is_unsigned = u; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'hDEADBEEF; divisor = 32'h0; is_unsigned = ~u;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!done && cnt < 80);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic u,
                     input int lat, input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
    int c;
    launch(a, b, u);
    wait_done(c);
    check({tag, "_latency"}, c, lat);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    check({tag, "_lo"}, lo, elo);
    check({tag, "_hi"}, hi, ehi);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_lo", lo, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    @(negedge clk) reset = 1'b0;

    run("p100_7", 32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2, 1'b0);
    run("n100_7", -32'd100, 32'd7, 1'b0, 34, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    run("p100_n7", 32'd100, -32'd7, 1'b0, 34, 32'hFFFFFFF2, 32'd2, 1'b0);
    run("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b0, 34, 32'h80000000, 32'd0, 1'b0);
    run("p100_7b", 32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2, 1'b0);
    run("div0", 32'd5, 32'd0, 1'b0, 1, 32'd14, 32'd2, 1'b1);

    launch(32'd50, 32'd5, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 32'd1; divisor = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("ignored_start_latency", n, 30);
    check("ignored_start_lo", lo, 32'd10);
    check("ignored_start_hi", hi, 32'd0);
    @(posedge clk); #1;

    launch(32'd1000, 32'd7, 1'b0);
    repeat (11) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_lo", lo, 32'd0);
    check("areset_hi", hi, 32'd0);
    check("areset_flags", {29'd0, busy, done, div_zero}, 32'd0);
    @(negedge clk) reset = 1'b0;
    run("after_reset", 32'd9, 32'd3, 1'b0, 34, 32'd3, 32'd0, 1'b0);

    run("pre_clear", 32'd7, 32'd2, 1'b0, 34, 32'd3, 32'd1, 1'b0);
    launch(32'd1000, 32'd7, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk) clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_lo", lo, 32'd0);
    check("clear_hi", hi, 32'd0);
    check("clear_flags", {29'd0, busy, done, div_zero}, 32'd0);
    wait_done(n);
    check("clear_no_done", {31'd0, done}, 32'd0);
    run("after_clear", 32'd9, 32'd3, 1'b0, 34, 32'd3, 32'd0, 1'b0);

    @(negedge clk);
    start = 1'b1; clear = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    check("clear_beats_start", {31'd0, busy}, 32'd0);

`ifdef DIVU_SUPPORT_EN
    run("divu", 32'hFFFFFFFF, 32'd2, 1'b1, 34, 32'h7FFFFFFF, 32'd1, 1'b0);
    run("div_m1_2", 32'hFFFFFFFF, 32'd2, 1'b0, 34, 32'd0, 32'hFFFFFFFF, 1'b0);
`else
    run("uns_ignored", 32'hFFFFFFFF, 32'd2, 1'b1, 34, 32'd0, 32'hFFFFFFFF, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
